pst_alt_sequencer: RTL

PST_ALT_SEQUENCER -- requirements
Module: pst_alt_sequencer

---
 rtl/pst_alt_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pst_alt_sequencer.sv
// Alternating-current stimulus sequencer for the 2-layer predictive core.
// Measures convergence latency (gamma cycles) after each input transition.
module pst_alt_sequencer #(
    parameter logic [7:0] CUR_A      = 8'd50,
    parameter logic [7:0] CUR_B      = 8'd20,
    parameter int         WARMUP_CYC = 20,
    parameter int         MEAS_CYC   = 8,
    parameter int         SETTLE_CYC = 8,
    parameter int         N_TRANS    = 6,
    parameter logic [7:0] ERR_TH     = 8'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        cycle_start,
    input  logic [7:0]  error_l2,
    output logic [7:0]  input_current,
    output logic        busy,
    output logic        done,
    output logic [2:0]  trans_idx,
    output logic        lat_valid,
    output logic [7:0]  lat_value,
    output logic [10:0] lat_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_MEAS,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t      state, state_d;
    logic [7:0]  cc, cc_d;
    logic [7:0]  cur, cur_d;
    logic [7:0]  lat_reg, lat_reg_d;
    logic [7:0]  lat_val, lat_val_d;
    logic [10:0] sum, sum_d;
    logic [2:0]  tidx, tidx_d;
    logic        hit, hit_d;
    logic        lat_vld, lat_vld_d;
    logic [7:0]  k;
    logic [7:0]  close_lat;
    logic [2:0]  tidx_nx;

    assign k         = cc + 8'd1;
    assign tidx_nx   = tidx + 3'd1;
    // A hit only on the final sample still reports the full window.
    assign close_lat = hit ? lat_reg : 8'(MEAS_CYC);

    always_comb begin
        state_d   = state;
        cc_d      = cc;
        cur_d     = cur;
        lat_reg_d = lat_reg;
        lat_val_d = lat_val;
        sum_d     = sum;
        tidx_d    = tidx;
        hit_d     = hit;
        lat_vld_d = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cc_d    = 8'd0;
            cur_d   = 8'd0;
            tidx_d  = 3'd0;
            hit_d   = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_WARMUP;
                        cc_d    = 8'd0;
                        cur_d   = CUR_A;
                        sum_d   = 11'd0;
                        tidx_d  = 3'd0;
                        hit_d   = 1'b0;
                    end
                end
                S_WARMUP: begin
                    if (cycle_start) begin
                        if (k == 8'(WARMUP_CYC)) begin
                            state_d = S_MEAS;
                            cc_d    = 8'd0;
                            tidx_d  = 3'd1;
                            cur_d   = CUR_B;
                            hit_d   = 1'b0;
                        end else begin
                            cc_d = k;
                        end
                    end
                end
                S_MEAS: begin
                    if (cycle_start) begin
                        cc_d = k;
                        if (error_l2 <= ERR_TH && !hit) begin
                            hit_d     = 1'b1;
                            lat_reg_d = k;
                        end
                        if (k == 8'(MEAS_CYC)) begin
                            lat_vld_d = 1'b1;
                            lat_val_d = close_lat;
                            sum_d     = sum + {3'd0, close_lat};
                            hit_d     = 1'b0;
                            cc_d      = 8'd0;
                            state_d   = (tidx == 3'(N_TRANS)) ? S_DONE
                                                             : S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cycle_start) begin
                        if (k == 8'(SETTLE_CYC)) begin
                            state_d = S_MEAS;
                            cc_d    = 8'd0;
                            tidx_d  = tidx_nx;
                            cur_d   = tidx_nx[0] ? CUR_B : CUR_A;
                            hit_d   = 1'b0;
                        end else begin
                            cc_d = k;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cc_d    = 8'd0;
                    cur_d   = 8'd0;
                    tidx_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cc      <= 8'd0;
            cur     <= 8'd0;
            lat_reg <= 8'd0;
            lat_val <= 8'd0;
            sum     <= 11'd0;
            tidx    <= 3'd0;
            hit     <= 1'b0;
            lat_vld <= 1'b0;
        end else begin
            state   <= state_d;
            cc      <= cc_d;
            cur     <= cur_d;
            lat_reg <= lat_reg_d;
            lat_val <= lat_val_d;
            sum     <= sum_d;
            tidx    <= tidx_d;
            hit     <= hit_d;
            lat_vld <= lat_vld_d;
        end
    end

    assign input_current = cur;
    assign busy          = (state == S_WARMUP) || (state == S_MEAS) ||
                           (state == S_SETTLE);
    assign done          = (state == S_DONE);
    assign trans_idx     = tidx;
    assign lat_valid     = lat_vld;
    assign lat_value     = lat_val;
    assign lat_sum       = sum;

endmodule
